// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the operand fetch slice: register-file geometry,
// the register select type, the operand bundle handed to execute, and a
// one-hot decode helper used by the pending scoreboard.
package cpu_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int SELW = 3;

  typedef logic [SELW-1:0] reg_sel_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    reg_sel_t      rd;
    logic          rd_en;
  } opnd_bundle_t;

  // One-hot decode of a register select, all zeros when not enabled.
  function automatic logic [NREG-1:0] sel_onehot(input reg_sel_t sel, input logic en);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    sel_onehot = en ? (one << sel) : {NREG{1'b0}};
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side instruction handshake and execute-side operand bundle handshake
// of the operand fetch stage. The slave modport is the operand fetch view;
// the master modport is the view of the decode/execute neighbours.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  reg_sel_t          in_rs1;
  reg_sel_t          in_rs2;
  reg_sel_t          in_rd;
  logic              in_rd_en;

  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_a;
  logic [DW-1:0]     out_b;
  reg_sel_t          out_rd;
  logic              out_rd_en;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_en, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_rd, out_rd_en
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en, out_ready,
    output in_ready, out_valid, out_a, out_b, out_rd, out_rd_en
  );

endinterface

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when an instruction that
// writes the register is issued, cleared when the regfile write lands. A set
// and clear on the same bit in one cycle keeps the bit set (new owner issued).
// Also reports RAW hazards for both sources and the WAW hazard on rd.
// With OPERAND_BYPASS_EN a same-cycle regfile write resolves the hazard.
module of_scoreboard
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_en_i,
  input  reg_sel_t        set_sel_i,
  input  logic            clr_en_i,
  input  reg_sel_t        clr_sel_i,
  input  reg_sel_t        rs1_i,
  input  reg_sel_t        rs2_i,
  input  reg_sel_t        rd_i,
  input  logic            rd_en_i,
  output logic [NREG-1:0] pending_o,
  output logic            haz_rs1_o,
  output logic            haz_rs2_o,
  output logic            haz_waw_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] resolved;
  logic [NREG-1:0] blocked;

  assign set_vec = sel_onehot(set_sel_i, set_en_i);
  assign clr_vec = sel_onehot(clr_sel_i, clr_en_i);

`ifdef OPERAND_BYPASS_EN
  // The write landing this cycle is forwarded, so it no longer blocks readers.
  assign resolved = clr_vec;
`else
  // No forwarding: a register stays blocked until its pending bit drops.
  assign resolved = {NREG{1'b0}};
`endif

  assign blocked   = pending_q & ~resolved;
  assign haz_rs1_o = blocked[rs1_i];
  assign haz_rs2_o = blocked[rs2_i];
  assign haz_waw_o = rd_en_i & blocked[rd_i];

  // Set has priority over clear on the same bit.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  // Pending vector register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= {NREG{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two sources from the regfile taps, stalls on
// RAW/WAW hazards tracked by of_scoreboard, and registers accepted
// instructions into a one-entry valid/ready stage feeding execute.
// Build option: define OPERAND_BYPASS_EN to forward same-cycle regfile write
// data to the sources and let that write resolve RAW/WAW hazards.
module operand_fetch #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DW-1:0]     q0,
  input  logic [DW-1:0]     q1,
  input  logic [DW-1:0]     q2,
  input  logic [DW-1:0]     q3,
  input  logic [DW-1:0]     q4,
  input  logic [DW-1:0]     q5,
  input  logic [DW-1:0]     q6,
  input  logic [DW-1:0]     q7,
  input  logic [DW-1:0]     wr_d,
  input  logic              wr_load,
  input  cpu_pkg::reg_sel_t wr_sel,
  operand_fetch_if.slave    bus,
  output logic [NREG-1:0]   pending,
  output logic [15:0]       stall_cnt
);

  logic [DW-1:0]         q_arr [NREG];
  logic [DW-1:0]         opnd_a_s;
  logic [DW-1:0]         opnd_b_s;
  logic                  haz_rs1_s;
  logic                  haz_rs2_s;
  logic                  haz_waw_s;
  logic                  hazard_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  out_valid_q;
  cpu_pkg::opnd_bundle_t bundle_q;
  cpu_pkg::opnd_bundle_t bundle_d;
  logic [15:0]           stall_q;

  assign q_arr[0] = q0;
  assign q_arr[1] = q1;
  assign q_arr[2] = q2;
  assign q_arr[3] = q3;
  assign q_arr[4] = q4;
  assign q_arr[5] = q5;
  assign q_arr[6] = q6;
  assign q_arr[7] = q7;

  of_scoreboard u_scoreboard (
    .clk_i     (CLK),
    .rst_i     (RST),
    .set_en_i  (accept_s & bus.in_rd_en),
    .set_sel_i (bus.in_rd),
    .clr_en_i  (wr_load),
    .clr_sel_i (wr_sel),
    .rs1_i     (bus.in_rs1),
    .rs2_i     (bus.in_rs2),
    .rd_i      (bus.in_rd),
    .rd_en_i   (bus.in_rd_en),
    .pending_o (pending),
    .haz_rs1_o (haz_rs1_s),
    .haz_rs2_o (haz_rs2_s),
    .haz_waw_o (haz_waw_s)
  );

  // Source read muxes, optionally overridden by the same-cycle regfile write.
  always_comb begin
    opnd_a_s = q_arr[bus.in_rs1];
    opnd_b_s = q_arr[bus.in_rs2];
`ifdef OPERAND_BYPASS_EN
    if (wr_load && (wr_sel == bus.in_rs1)) begin
      opnd_a_s = wr_d;
    end else begin
      opnd_a_s = q_arr[bus.in_rs1];
    end
    if (wr_load && (wr_sel == bus.in_rs2)) begin
      opnd_b_s = wr_d;
    end else begin
      opnd_b_s = q_arr[bus.in_rs2];
    end
`endif
  end

  // in_ready never looks at in_valid, only at the output stage and hazards.
  assign hazard_s   = haz_rs1_s | haz_rs2_s | haz_waw_s;
  assign in_ready_s = !RST && (!out_valid_q || bus.out_ready) && !hazard_s;
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bundle_d.a     = opnd_a_s;
  assign bundle_d.b     = opnd_b_s;
  assign bundle_d.rd    = bus.in_rd;
  assign bundle_d.rd_en = bus.in_rd_en;

  // Output stage: load on accept, drop when consumed without a replacement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (accept_s) begin
      out_valid_q <= 1'b1;
      bundle_q    <= bundle_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Saturating count of cycles where decode offered but was not accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= 16'h0000;
    end else if (bus.in_valid && !in_ready_s && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = bundle_q.a;
  assign bus.out_b     = bundle_q.b;
  assign bus.out_rd    = bundle_q.rd;
  assign bus.out_rd_en = bundle_q.rd_en;
  assign stall_cnt     = stall_q;

endmodule
